// File: rtl/iot_dev_pkg.sv
// Shared types and sizing helpers for the IOT serial device.
package iot_dev_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/iot_serial_device_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling, glitch and framing checks.
module iot_uart_rx
    import iot_dev_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       ferr
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic            sync1_r, sync2_r;
    rx_state_t       state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [2:0]      idx_r, idx_s;
    logic [7:0]      shreg_r, shreg_s;
    logic            valid_r, valid_s;
    logic            ferr_r, ferr_s;

    // Next-state logic: start sampled at half a bit, then every full bit period.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CW'(1);
        idx_s   = idx_r;
        shreg_s = shreg_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (!sync2_r) state_s = RX_START;
                else          state_s = RX_IDLE;
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = {CW{1'b0}};
                    idx_s = 3'd0;
                    if (!sync2_r) state_s = RX_DATA;
                    else          state_s = RX_IDLE;
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    shreg_s = {sync2_r, shreg_r[7:1]};
                    idx_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) state_s = RX_STOP;
                    else               state_s = RX_DATA;
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = RX_IDLE;
                    if (sync2_r) valid_s = 1'b1;
                    else         ferr_s  = 1'b1;
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                state_s = RX_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            state_r <= RX_IDLE;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= 3'd0;
            shreg_r <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
        end
    end

    assign byte_valid = valid_r;
    assign rx_byte    = shreg_r;
    assign ferr       = ferr_r;

endmodule

// File: rtl/iot_serial_device.sv
// PDP-8 IOT console device: 8N1 transmitter plus receive flag/holding register.
module iot_serial_device
    import iot_dev_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit CLEAR_ACC    = 1'b1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] dataout,
    output logic       ready,
    output logic       clearacc,
    output logic [7:0] datain,
    input  logic       rxd,
    output logic       txd,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       rx_ferr
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     tx_state_r, tx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]    tx_idx_r, tx_idx_s;
    logic [7:0]    tx_shreg_r, tx_shreg_s;
    logic          txd_r, txd_s;
    logic          tx_busy_r, tx_busy_s;

    logic          ready_r, ready_s;
    logic          clearacc_r, clearacc_s;
    logic [7:0]    datain_r, datain_s;
    logic          ovr_r, ovr_s;

    logic          rx_valid_s;
    logic [7:0]    rx_byte_s;
    logic          rx_ferr_s;

    iot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .nrst       (nrst),
        .rxd        (rxd),
        .byte_valid (rx_valid_s),
        .rx_byte    (rx_byte_s),
        .ferr       (rx_ferr_s)
    );

    // TX next-state: txd is computed one step ahead so the pin itself is a flop.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + CW'(1);
        tx_idx_s   = tx_idx_r;
        tx_shreg_s = tx_shreg_r;
        txd_s      = txd_r;
        tx_busy_s  = tx_busy_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = {CW{1'b0}};
                if (load) begin
                    tx_state_s = TX_START;
                    tx_shreg_s = dataout;
                    txd_s      = 1'b0;
                    tx_busy_s  = 1'b1;
                end else begin
                    tx_state_s = TX_IDLE;
                    txd_s      = 1'b1;
                    tx_busy_s  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_r == FULL_LAST) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = {CW{1'b0}};
                    tx_idx_s   = 3'd0;
                    txd_s      = tx_shreg_r[0];
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == FULL_LAST) begin
                    tx_cnt_s = {CW{1'b0}};
                    if (tx_idx_r == 3'd7) begin
                        tx_state_s = TX_STOP;
                        txd_s      = 1'b1;
                    end else begin
                        tx_state_s = TX_DATA;
                        tx_idx_s   = tx_idx_r + 3'd1;
                        tx_shreg_s = {1'b0, tx_shreg_r[7:1]};
                        txd_s      = tx_shreg_r[1];
                    end
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == FULL_LAST) begin
                    tx_state_s = TX_IDLE;
                    tx_cnt_s   = {CW{1'b0}};
                    tx_busy_s  = 1'b0;
                    txd_s      = 1'b1;
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = {CW{1'b0}};
                txd_s      = 1'b1;
                tx_busy_s  = 1'b0;
            end
        endcase
    end

    // Flag logic: a completing byte beats a coincident clear, but overrun never survives a clear.
    always_comb begin
        if (rx_valid_s) begin
            ready_s  = 1'b1;
            datain_s = rx_byte_s;
        end else begin
            ready_s  = clear ? 1'b0 : ready_r;
            datain_s = datain_r;
        end
        if (clear) begin
            ovr_s = 1'b0;
        end else if (rx_valid_s && ready_r) begin
            ovr_s = 1'b1;
        end else begin
            ovr_s = ovr_r;
        end
        if (CLEAR_ACC) clearacc_s = ready_s;
        else           clearacc_s = 1'b0;
    end

    // TX and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= {CW{1'b0}};
            tx_idx_r   <= 3'd0;
            tx_shreg_r <= 8'h00;
            txd_r      <= 1'b1;
            tx_busy_r  <= 1'b0;
            ready_r    <= 1'b0;
            clearacc_r <= 1'b0;
            datain_r   <= 8'h00;
            ovr_r      <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_idx_r   <= tx_idx_s;
            tx_shreg_r <= tx_shreg_s;
            txd_r      <= txd_s;
            tx_busy_r  <= tx_busy_s;
            ready_r    <= ready_s;
            clearacc_r <= clearacc_s;
            datain_r   <= datain_s;
            ovr_r      <= ovr_s;
        end
    end

    assign txd        = txd_r;
    assign tx_busy    = tx_busy_r;
    assign ready      = ready_r;
    assign clearacc   = clearacc_r;
    assign datain     = datain_r;
    assign rx_overrun = ovr_r;
    assign rx_ferr    = rx_ferr_s;

endmodule

// File: tb/tb_iot_serial_device.sv
// Scoreboard bench for iot_serial_device: expected TX frames and RX flag events are queued by stimulus, checked by monitors.
module tb_iot_serial_device;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       nrst, clear, load, rxd;
    logic [7:0] dataout;

    logic       ready_a, clearacc_a, txd_a, tx_busy_a, rx_overrun_a, rx_ferr_a;
    logic [7:0] datain_a;
    logic       ready_b, clearacc_b, txd_b, tx_busy_b, rx_overrun_b, rx_ferr_b;
    logic [7:0] datain_b;

    iot_serial_device #(.CLKS_PER_BIT(CPB), .CLEAR_ACC(1'b1)) dut_a (
        .clk(clk), .nrst(nrst), .clear(clear), .load(load), .dataout(dataout),
        .ready(ready_a), .clearacc(clearacc_a), .datain(datain_a), .rxd(rxd),
        .txd(txd_a), .tx_busy(tx_busy_a), .rx_overrun(rx_overrun_a), .rx_ferr(rx_ferr_a)
    );

    iot_serial_device #(.CLKS_PER_BIT(CPB), .CLEAR_ACC(1'b0)) dut_b (
        .clk(clk), .nrst(nrst), .clear(clear), .load(load), .dataout(dataout),
        .ready(ready_b), .clearacc(clearacc_b), .datain(datain_b), .rxd(rxd),
        .txd(txd_b), .tx_busy(tx_busy_b), .rx_overrun(rx_overrun_b), .rx_ferr(rx_ferr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       ferr;
        logic       rdy;
        logic [7:0] d;
        logic       ovr;
    } rx_exp_t;

    typedef struct {
        logic [7:0] d;
        int         start;
    } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];

    // reference model state
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         tx_free = 0;
    logic       saw_b_clearacc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic ferr);
        rx_exp_t e;
        e.ferr = ferr;
        e.rdy  = m_ready;
        e.d    = m_data;
        e.ovr  = m_ovr;
        rx_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int idle);
        step();
        rxd = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) step();
        end
        rxd = stop_bit;
        repeat (CPB) step();
        rxd = 1'b1;
        repeat (idle) step();
    endtask

    task automatic rx_ok(input logic [7:0] d);
        m_ovr   = m_ovr | m_ready;
        m_ready = 1'b1;
        m_data  = d;
        push_rx(1'b0);
        send_frame(d, 1'b1, 4);
    endtask

    task automatic model_clear();
        if (m_ready || m_ovr) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
            push_rx(1'b0);
        end
    endtask

    task automatic rx_clear();
        step();
        clear = 1'b1;
        model_clear();
        step();
        clear = 1'b0;
    endtask

    // t is the clock edge at which load is sampled
    task automatic load_at(input int t, input logic [7:0] d, input logic with_clear);
        tx_exp_t e;
        while (cyc < t - 1) step();
        load    = 1'b1;
        dataout = d;
        if (t >= tx_free) begin
            e.d     = d;
            e.start = t;
            tx_q.push_back(e);
            tx_free = t + 1 + 10 * CPB;
        end
        if (with_clear) begin
            clear = 1'b1;
            model_clear();
        end
        step();
        load    = 1'b0;
        clear   = 1'b0;
        dataout = 8'($urandom);
    endtask

    // TX monitor: decode each frame from txd and compare against the queued byte and start edge
    initial begin : tx_mon
        logic prev;
        int c, errs;
        tx_exp_t e;
        logic [9:0] fr;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && prev === 1'b1 && txd_a === 1'b0) begin
                c = cyc;
                if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_frame: frame start at cycle %0d, none expected", c);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_start_cycle", c, e.start);
                    fr   = {1'b1, e.d, 1'b0};
                    errs = 0;
                    for (int b = 0; b < 10; b++) begin
                        for (int j = 0; j < CPB; j++) begin
                            if (b != 0 || j != 0) @(negedge clk);
                            if (txd_a !== fr[b] || tx_busy_a !== 1'b1 || txd_b !== fr[b]) errs++;
                        end
                    end
                    check("tx_frame_bits", errs, 0);
                    @(negedge clk);
                    check("tx_busy_fall", {tx_busy_a, txd_a}, 2'b01);
                end
            end
            prev = txd_a;
        end
    end

    // RX monitor: every visible change of the flag state (or an rx_ferr pulse) pops one expectation
    initial begin : rx_mon
        logic [10:0] prev, cur;
        logic chk_pulse;
        rx_exp_t e;
        chk_pulse = 1'b0;
        prev = 11'h000;
        forever begin
            @(negedge clk);
            cur = {ready_a, clearacc_a, rx_overrun_a, datain_a};
            if (clearacc_b === 1'b1) saw_b_clearacc = 1'b1;
            if (chk_pulse) begin
                check("rx_ferr_one_cycle", rx_ferr_a, 1'b0);
                chk_pulse = 1'b0;
            end
            if (nrst === 1'b1 && (cur !== prev || rx_ferr_a === 1'b1)) begin
                if (rx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected_event: ready=%b datain=%h ovr=%b ferr=%b, none expected",
                             ready_a, datain_a, rx_overrun_a, rx_ferr_a);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_event", {rx_ferr_a, ready_a, rx_overrun_a, datain_a}, {e.ferr, e.rdy, e.ovr, e.d});
                    check("rx_clearacc", clearacc_a, e.rdy);
                    check("rx_no_clearacc_mode", {clearacc_b, ready_b, rx_overrun_b, datain_b},
                          {1'b0, e.rdy, e.ovr, e.d});
                    if (e.ferr) chk_pulse = 1'b1;
                end
            end
            prev = cur;
        end
    end

    initial begin : stim
        int n, errs, w;
        logic [7:0] d;

        nrst = 1'b0; load = 1'b1; clear = 1'b0; rxd = 1'b1; dataout = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values_a", {ready_a, clearacc_a, datain_a, txd_a, tx_busy_a, rx_overrun_a, rx_ferr_a},
              {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_values_b", {ready_b, clearacc_b, datain_b, txd_b, tx_busy_b, rx_overrun_b, rx_ferr_b},
              {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        nrst = 1'b1;
        load = 1'b0;

        errs = 0;
        repeat (50) begin
            step();
            if (txd_a !== 1'b1 || tx_busy_a !== 1'b0) errs++;
        end
        check("no_tx_after_reset_load", errs, 0);

        // abandon a partially received frame with reset
        step();
        rxd = 1'b0;
        repeat (15) step();
        nrst = 1'b0;
        rxd  = 1'b1;
        repeat (2) step();
        check("reset_mid_rx", {ready_a, datain_a, rx_overrun_a, rx_ferr_a}, {1'b0, 8'h00, 1'b0, 1'b0});
        nrst = 1'b1;
        repeat (5) step();

        rx_ok(8'h5A);
        rx_clear();

        rx_ok(8'h11);
        rx_ok(8'h22);
        // third byte completes on the very edge that samples clear
        m_ready = 1'b1; m_data = 8'h33; m_ovr = 1'b0;
        push_rx(1'b0);
        fork
            send_frame(8'h33, 1'b1, 4);
            begin
                repeat (42) step();
                clear = 1'b1;
                step();
                clear = 1'b0;
            end
        join
        rx_clear();

        push_rx(1'b1);
        send_frame(8'h77, 1'b0, 8);

        step();
        rxd = 1'b0;
        step();
        rxd = 1'b1;
        repeat (12) step();

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (m_ready && d == m_data) d = d ^ 8'h01;
            rx_ok(d);
            if ($urandom_range(0, 1) == 1) rx_clear();
        end

        n = cyc + 2;
        load_at(n, 8'hA5, 1'b0);
        load_at(n + 10, 8'h3C, 1'b0);
        load_at(n + 41, 8'h3C, 1'b0);

        for (int i = 0; i < 8; i++) begin
            load_at(cyc + 1 + $urandom_range(0, 45), 8'($urandom), 1'b0);
        end

        while (cyc < tx_free) step();
        rx_ok(m_data ^ 8'hFF);
        load_at(cyc + 2, 8'hC3, 1'b1);

        w = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || cyc < tx_free + 2) && w < 3000) begin
            step();
            w++;
        end
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        check("clearacc_off_never_high", saw_b_clearacc, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
